mem_stage: RTL and testbench
============================

Name: mem_stage

Overview:
- Memory stage of the RV32I pipeline; consumes the execute-stage result bundle (type/sub-type, ALU result, store value, rd).
- Performs loads/stores over a req/ack data-memory port and produces the memory-stage bypass pair (bp_mem_reg/bp_mem_val) back to execute.
- Drives the writeback bundle to the register file.
- Asserts mem_stall while a memory access is outstanding so upstream stages hold.

Parameters:
- ACK_TIMEOUT, 16: max cycles dmem_req stays high without dmem_ack before abort; 0 disables the timeout.

Ports:
- clk  in  1  pipeline clock, rising edge
- rst_n  in  1  reset, asynchronous, active-low
- ex_valid  in  1  execute bundle valid this cycle
- ex_insn_type  in  4  instruction type (AR/L/S/DB/IB)
- ex_insn_sub_type  in  4  sub-type; for L/S it is funct3
- ex_val  in  32  ALU result, which is the effective address for L/S
- ex_store_val  in  32  store data (rs2, already forwarded)
- ex_rd  in  5  destination register
- mem_stall  out  1  upstream hold
- dmem_req  out  1  access request
- dmem_we  out  1  1 = store
- dmem_addr  out  32  word-aligned address
- dmem_wdata  out  32  lane-replicated store data
- dmem_be  out  4  byte enables
- dmem_ack  in  1  access done; dmem_rdata valid
- dmem_rdata  in  32  read word
- bp_mem_reg  out  5  bypass register; 0 = none
- bp_mem_val  out  32  bypass value
- wb_valid  out  1  writeback strobe
- wb_reg  out  5  writeback register
- wb_val  out  32  writeback value
- misalign_err  out  1  one-cycle pulse on a misaligned L/S
- bus_err  out  1  one-cycle pulse on an ack timeout

Behaviour:
- Reset (async, rst_n=0):
  - All outputs 0; state IDLE; timeout counter 0.
  - Reset asserted mid-access drops dmem_req immediately and discards the access.
- States:
  - IDLE, ACCESS.
  - mem_stall = (state==ACCESS).
  - Inputs are sampled only in IDLE with ex_valid=1.
- Writers of rd:
  - AR_TYPE, IB_TYPE, and DB_TYPE with sub-type DB_JAL.
  - Other DB sub-types and S_TYPE write nothing.
- Non-memory writer (IDLE, ex_valid):
  - Next edge: wb_valid=(ex_rd!=0), wb_reg=ex_rd, wb_val=ex_val.
  - bp_mem_reg=ex_rd; bp_mem_val = ex_rd==0 ? 0 : ex_val.
- Non-writer, or ex_valid=0:
  - Next edge: wb_valid=0, bp_mem_reg=0, bp_mem_val=0.
- Load/store accepted (IDLE, ex_valid, aligned):
  - Next edge: state ACCESS, dmem_req=1, dmem_addr={ex_val[31:2],2'b00}, dmem_we=(S_TYPE).
  - Latch the offset ex_val[1:0], sub-type and rd.
  - wb_valid=0, bp_mem_reg=0.
- Byte enables and store data:
  - Byte (sub 0/4): be=4'b0001<<off; wdata={4{st[7:0]}}.
  - Half (sub 1/5): be=4'b0011<<off; wdata={2{st[15:0]}}.
  - Word (sub 2): be=4'hF; wdata=st.
  - Loads drive the same be; wdata=0.
- Alignment:
  - Halfword requires off[0]=0; word requires off=0.
  - Violation: no request, state stays IDLE, misalign_err=1 for one cycle, wb_valid=0, bp_mem_reg=0.
- ACCESS with dmem_ack=1 (may be the first ACCESS cycle):
  - Next edge: state IDLE, dmem_req=0.
  - For a load: select the lane by off; LB/LH sign-extend, LBU/LHU zero-extend, LW takes the whole word.
  - Load results update wb_*/bp_* by the writer rule; rd=0 gives wb_valid=0 and bp_mem_val=0.
  - A store produces no writeback.
- Stall and throughput:
  - Minimum load/store stall is 1 cycle (ack in the first ACCESS cycle).
  - Loaded value visible on bp_mem_* and wb_* the edge after ack.
- Timeout:
  - Counter increments each ACCESS cycle without ack.
  - When the counter reaches ACK_TIMEOUT (ACK_TIMEOUT≠0): abort to IDLE, dmem_req=0, bus_err pulse, no writeback.
  - An ack arriving in the same cycle as the timeout wins.
- Spurious input: dmem_ack while IDLE is ignored; dmem_rdata is sampled only on ack in ACCESS.
- Outputs are held during ACCESS: wb_valid=0 and bp_mem_reg=0 while stalled.

Decomposition:
- Shared include exec_insn_types.v holds AR_TYPE/L_TYPE/S_TYPE/DB_TYPE/IB_TYPE and DB_JAL.
- Add to it: LS_B=0, LS_H=1, LS_W=2, LS_BU=4, LS_HU=5.
- Sub-module mem_lane_align (combinational) does be/wdata generation plus load extraction and extension; the FSM, counter and registers stay in mem_stage.

Test Plan:
- AR write: ex_rd=5, ex_val=32'h1234 -> next edge wb_valid=1, wb_reg=5, wb_val=32'h1234, bp_mem_reg=5, bp_mem_val=32'h1234, mem_stall=0.
- LB with sign extension:
  - Stimulus: addr=32'h103 → dmem_req=1, addr=32'h100, be=4'b1000, mem_stall=1; ack after 3 cycles with rdata=32'h80FF_FF00.
  - Response: wb_val=32'hFFFF_FF80; LBU on the same data gives 32'h0000_0080.
- SH addr=32'h202, st=32'hABCD → be=4'b1100, wdata=32'hABCD_ABCD, dmem_we=1, no writeback, bp_mem_reg=0.
- Misalignment: LW addr=32'h101 -> no dmem_req, misalign_err one cycle, state IDLE; LH addr=32'h102 is accepted.
- Timeout: ACK_TIMEOUT=4 with no ack -> dmem_req high 4 cycles, then bus_err pulse, mem_stall deasserts, no writeback.
- Reset and rd=0:
  - rst_n low mid-ACCESS → dmem_req=0 asynchronously; after release, a load with ex_rd=0 gives wb_valid=0, bp_mem_val=0.

Source files
------------

// File: rtl/mem_stage_pkg.sv
// Shared encodings for the memory stage: instruction types, load/store widths, FSM states.
package mem_stage_pkg;

    // Instruction types from execute
    localparam logic [3:0] AR_TYPE = 4'd0;
    localparam logic [3:0] L_TYPE  = 4'd1;
    localparam logic [3:0] S_TYPE  = 4'd2;
    localparam logic [3:0] DB_TYPE = 4'd3;
    localparam logic [3:0] IB_TYPE = 4'd4;

    // Direct-branch sub-type that links into rd
    localparam logic [3:0] DB_JAL  = 4'd8;

    // Load/store sub-types (funct3)
    localparam logic [3:0] LS_B    = 4'd0;
    localparam logic [3:0] LS_H    = 4'd1;
    localparam logic [3:0] LS_W    = 4'd2;
    localparam logic [3:0] LS_BU   = 4'd4;
    localparam logic [3:0] LS_HU   = 4'd5;

    typedef enum logic [0:0] {
        StIdle,
        StAccess
    } mem_state_e;

    // True for non-memory instructions that write rd
    function automatic logic is_rd_writer(input logic [3:0] insn_type, input logic [3:0] sub_type);
        return (insn_type == AR_TYPE) || (insn_type == IB_TYPE) ||
               ((insn_type == DB_TYPE) && (sub_type == DB_JAL));
    endfunction

endpackage

// File: rtl/mem_lane_align.sv
// Byte-lane handling: request-side byte enables / store replication / alignment check,
// and response-side lane extraction with sign or zero extension.
module mem_lane_align
    import mem_stage_pkg::*;
(
    input  logic [1:0]  off,
    input  logic [3:0]  sub,
    input  logic        is_store,
    input  logic [31:0] store_val,
    input  logic [1:0]  ld_off,
    input  logic [3:0]  ld_sub,
    input  logic [31:0] rdata,
    output logic [3:0]  be,
    output logic [31:0] wdata,
    output logic        misaligned,
    output logic [31:0] load_val
);

    logic [31:0] shifted;

    // Byte enables, replicated store data and alignment for the incoming access
    always_comb begin
        be         = 4'h0;
        wdata      = 32'h0;
        misaligned = 1'b0;
        case (sub)
            LS_B, LS_BU: begin
                be    = 4'b0001 << off;
                wdata = {4{store_val[7:0]}};
            end
            LS_H, LS_HU: begin
                be         = 4'b0011 << off;
                wdata      = {2{store_val[15:0]}};
                misaligned = off[0];
            end
            default: begin
                be         = 4'hF;
                wdata      = store_val;
                misaligned = |off;
            end
        endcase
        if (!is_store) begin
            wdata = 32'h0;
        end
    end

    assign shifted = rdata >> {ld_off, 3'b000};

    // Lane select and extension of the returned word for the latched load
    always_comb begin
        load_val = rdata;
        case (ld_sub)
            LS_B:    load_val = {{24{shifted[7]}}, shifted[7:0]};
            LS_BU:   load_val = {24'h0, shifted[7:0]};
            LS_H:    load_val = {{16{shifted[15]}}, shifted[15:0]};
            LS_HU:   load_val = {16'h0, shifted[15:0]};
            default: load_val = rdata;
        endcase
    end

endmodule

// File: rtl/mem_stage.sv
// RV32I memory stage: issues loads/stores on a req/ack port, stalls upstream while an
// access is outstanding, and produces the bypass pair and writeback bundle.
module mem_stage
    import mem_stage_pkg::*;
#(
    parameter int unsigned ACK_TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        ex_valid,
    input  logic [3:0]  ex_insn_type,
    input  logic [3:0]  ex_insn_sub_type,
    input  logic [31:0] ex_val,
    input  logic [31:0] ex_store_val,
    input  logic [4:0]  ex_rd,
    output logic        mem_stall,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [31:0] dmem_addr,
    output logic [31:0] dmem_wdata,
    output logic [3:0]  dmem_be,
    input  logic        dmem_ack,
    input  logic [31:0] dmem_rdata,
    output logic [4:0]  bp_mem_reg,
    output logic [31:0] bp_mem_val,
    output logic        wb_valid,
    output logic [4:0]  wb_reg,
    output logic [31:0] wb_val,
    output logic        misalign_err,
    output logic        bus_err
);

    localparam int unsigned CntW = (ACK_TIMEOUT < 2) ? 1 : $clog2(ACK_TIMEOUT + 1);
    localparam logic [CntW-1:0] TimeoutVal = CntW'(ACK_TIMEOUT);

    mem_state_e state_q, state_d;

    logic            req_q, req_d;
    logic            we_q, we_d;
    logic [31:0]     addr_q, addr_d;
    logic [31:0]     wdata_q, wdata_d;
    logic [3:0]      be_q, be_d;
    logic [1:0]      off_q, off_d;
    logic [3:0]      sub_q, sub_d;
    logic [4:0]      rd_q, rd_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic            wb_valid_q, wb_valid_d;
    logic [4:0]      wb_reg_q, wb_reg_d;
    logic [31:0]     wb_val_q, wb_val_d;
    logic [4:0]      bp_reg_q, bp_reg_d;
    logic [31:0]     bp_val_q, bp_val_d;
    logic            mis_q, mis_d;
    logic            bus_err_q, bus_err_d;

    logic            is_ls;
    logic            is_store;
    logic [3:0]      lane_be;
    logic [31:0]     lane_wdata;
    logic            lane_misaligned;
    logic [31:0]     load_val;
    logic [CntW-1:0] cnt_inc;

    assign is_ls    = (ex_insn_type == L_TYPE) || (ex_insn_type == S_TYPE);
    assign is_store = (ex_insn_type == S_TYPE);
    assign cnt_inc  = cnt_q + CntW'(1);

    mem_lane_align u_lane (
        .off        (ex_val[1:0]),
        .sub        (ex_insn_sub_type),
        .is_store   (is_store),
        .store_val  (ex_store_val),
        .ld_off     (off_q),
        .ld_sub     (sub_q),
        .rdata      (dmem_rdata),
        .be         (lane_be),
        .wdata      (lane_wdata),
        .misaligned (lane_misaligned),
        .load_val   (load_val)
    );

    // Next-state: accept in IDLE, complete or time out in ACCESS
    always_comb begin
        state_d    = state_q;
        req_d      = req_q;
        we_d       = we_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        be_d       = be_q;
        off_d      = off_q;
        sub_d      = sub_q;
        rd_d       = rd_q;
        cnt_d      = cnt_q;
        wb_valid_d = 1'b0;
        wb_reg_d   = wb_reg_q;
        wb_val_d   = wb_val_q;
        bp_reg_d   = 5'd0;
        bp_val_d   = 32'h0;
        mis_d      = 1'b0;
        bus_err_d  = 1'b0;

        unique case (state_q)
            StIdle: begin
                req_d = 1'b0;
                cnt_d = '0;
                if (ex_valid) begin
                    if (is_ls) begin
                        if (lane_misaligned) begin
                            mis_d = 1'b1;
                        end else begin
                            state_d = StAccess;
                            req_d   = 1'b1;
                            we_d    = is_store;
                            addr_d  = {ex_val[31:2], 2'b00};
                            be_d    = lane_be;
                            wdata_d = lane_wdata;
                            off_d   = ex_val[1:0];
                            sub_d   = ex_insn_sub_type;
                            rd_d    = ex_rd;
                        end
                    end else if (is_rd_writer(ex_insn_type, ex_insn_sub_type)) begin
                        wb_valid_d = (ex_rd != 5'd0);
                        wb_reg_d   = ex_rd;
                        wb_val_d   = ex_val;
                        bp_reg_d   = ex_rd;
                        bp_val_d   = (ex_rd == 5'd0) ? 32'h0 : ex_val;
                    end
                end
            end
            StAccess: begin
                // Ack wins over a simultaneous timeout
                if (dmem_ack) begin
                    state_d = StIdle;
                    req_d   = 1'b0;
                    cnt_d   = '0;
                    if (!we_q) begin
                        wb_valid_d = (rd_q != 5'd0);
                        wb_reg_d   = rd_q;
                        wb_val_d   = load_val;
                        bp_reg_d   = rd_q;
                        bp_val_d   = (rd_q == 5'd0) ? 32'h0 : load_val;
                    end
                end else if (ACK_TIMEOUT != 0) begin
                    if (cnt_inc == TimeoutVal) begin
                        state_d   = StIdle;
                        req_d     = 1'b0;
                        cnt_d     = '0;
                        bus_err_d = 1'b1;
                    end else begin
                        cnt_d = cnt_inc;
                    end
                end
            end
            default: begin
                state_d = StIdle;
                req_d   = 1'b0;
            end
        endcase
    end

    // State and output registers; reset also abandons any in-flight access
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= StIdle;
            req_q      <= 1'b0;
            we_q       <= 1'b0;
            addr_q     <= 32'h0;
            wdata_q    <= 32'h0;
            be_q       <= 4'h0;
            off_q      <= 2'd0;
            sub_q      <= 4'd0;
            rd_q       <= 5'd0;
            cnt_q      <= '0;
            wb_valid_q <= 1'b0;
            wb_reg_q   <= 5'd0;
            wb_val_q   <= 32'h0;
            bp_reg_q   <= 5'd0;
            bp_val_q   <= 32'h0;
            mis_q      <= 1'b0;
            bus_err_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            req_q      <= req_d;
            we_q       <= we_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            be_q       <= be_d;
            off_q      <= off_d;
            sub_q      <= sub_d;
            rd_q       <= rd_d;
            cnt_q      <= cnt_d;
            wb_valid_q <= wb_valid_d;
            wb_reg_q   <= wb_reg_d;
            wb_val_q   <= wb_val_d;
            bp_reg_q   <= bp_reg_d;
            bp_val_q   <= bp_val_d;
            mis_q      <= mis_d;
            bus_err_q  <= bus_err_d;
        end
    end

    assign mem_stall    = (state_q == StAccess);
    assign dmem_req     = req_q;
    assign dmem_we      = we_q;
    assign dmem_addr    = addr_q;
    assign dmem_wdata   = wdata_q;
    assign dmem_be      = be_q;
    assign wb_valid     = wb_valid_q;
    assign wb_reg       = wb_reg_q;
    assign wb_val       = wb_val_q;
    assign bp_mem_reg   = bp_reg_q;
    assign bp_mem_val   = bp_val_q;
    assign misalign_err = mis_q;
    assign bus_err      = bus_err_q;

endmodule

// File: tb/tb_mem_stage.sv
// Directed bench for mem_stage: a vector table of single transactions plus hand-written
// sequences for multi-cycle waits, timeout, ack/timeout race and mid-access reset.
module tb_mem_stage;
    import mem_stage_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        ex_valid = 1'b0;
    logic [3:0]  ex_insn_type = 4'd0;
    logic [3:0]  ex_insn_sub_type = 4'd0;
    logic [31:0] ex_val = 32'h0;
    logic [31:0] ex_store_val = 32'h0;
    logic [4:0]  ex_rd = 5'd0;
    logic        mem_stall;
    logic        dmem_req;
    logic        dmem_we;
    logic [31:0] dmem_addr;
    logic [31:0] dmem_wdata;
    logic [3:0]  dmem_be;
    logic        dmem_ack = 1'b0;
    logic [31:0] dmem_rdata = 32'h0;
    logic [4:0]  bp_mem_reg;
    logic [31:0] bp_mem_val;
    logic        wb_valid;
    logic [4:0]  wb_reg;
    logic [31:0] wb_val;
    logic        misalign_err;
    logic        bus_err;

    int total = 0;
    int bad = 0;

    mem_stage #(.ACK_TIMEOUT(4)) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .ex_valid         (ex_valid),
        .ex_insn_type     (ex_insn_type),
        .ex_insn_sub_type (ex_insn_sub_type),
        .ex_val           (ex_val),
        .ex_store_val     (ex_store_val),
        .ex_rd            (ex_rd),
        .mem_stall        (mem_stall),
        .dmem_req         (dmem_req),
        .dmem_we          (dmem_we),
        .dmem_addr        (dmem_addr),
        .dmem_wdata       (dmem_wdata),
        .dmem_be          (dmem_be),
        .dmem_ack         (dmem_ack),
        .dmem_rdata       (dmem_rdata),
        .bp_mem_reg       (bp_mem_reg),
        .bp_mem_val       (bp_mem_val),
        .wb_valid         (wb_valid),
        .wb_reg           (wb_reg),
        .wb_val           (wb_val),
        .misalign_err     (misalign_err),
        .bus_err          (bus_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        is_mem;
        logic [3:0]  typ;
        logic [3:0]  sub;
        logic [31:0] val;
        logic [31:0] st;
        logic [4:0]  rd;
        logic [31:0] rdata;
        logic        e_mis;
        logic [3:0]  e_be;
        logic [31:0] e_addr;
        logic [31:0] e_wdata;
        logic        e_we;
        logic        e_wbv;
        logic [4:0]  e_bpr;
        logic [31:0] e_bpv;
        logic        a_wbv;
        logic [4:0]  a_rd;
        logic [31:0] a_val;
    } vec_t;

    function automatic vec_t v_alu(input logic [3:0] typ, input logic [3:0] sub,
                                   input logic [4:0] rd, input logic [31:0] val,
                                   input logic wbv, input logic [4:0] bpr,
                                   input logic [31:0] bpv);
        vec_t v;
        v = '{default: '0};
        v.typ = typ; v.sub = sub; v.rd = rd; v.val = val;
        v.e_wbv = wbv; v.e_bpr = bpr; v.e_bpv = bpv;
        return v;
    endfunction

    function automatic vec_t v_mem(input logic [3:0] typ, input logic [3:0] sub,
                                   input logic [31:0] addr, input logic [31:0] st,
                                   input logic [4:0] rd, input logic [31:0] rdata,
                                   input logic mis, input logic [31:0] e_addr,
                                   input logic [3:0] e_be, input logic [31:0] e_wdata,
                                   input logic a_wbv, input logic [4:0] a_rd,
                                   input logic [31:0] a_val);
        vec_t v;
        v = '{default: '0};
        v.is_mem = 1'b1; v.typ = typ; v.sub = sub; v.val = addr; v.st = st; v.rd = rd;
        v.rdata = rdata; v.e_mis = mis; v.e_addr = e_addr; v.e_be = e_be;
        v.e_wdata = e_wdata; v.e_we = (typ == S_TYPE);
        v.a_wbv = a_wbv; v.a_rd = a_rd; v.a_val = a_val;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    task automatic drive(input logic [3:0] typ, input logic [3:0] sub, input logic [31:0] val,
                         input logic [31:0] st, input logic [4:0] rd);
        @(negedge clk);
        ex_insn_type = typ;
        ex_insn_sub_type = sub;
        ex_val = val;
        ex_store_val = st;
        ex_rd = rd;
        ex_valid = 1'b1;
        @(negedge clk);
        ex_valid = 1'b0;
    endtask

    vec_t vecs[14];
    int   n;

    initial begin
        vecs[0]  = v_alu(AR_TYPE, 4'd0, 5'd5, 32'h1234, 1'b1, 5'd5, 32'h1234);
        vecs[1]  = v_alu(IB_TYPE, 4'd0, 5'd0, 32'hDEAD, 1'b0, 5'd0, 32'h0);
        vecs[2]  = v_alu(DB_TYPE, DB_JAL, 5'd1, 32'h44, 1'b1, 5'd1, 32'h44);
        vecs[3]  = v_alu(DB_TYPE, 4'd1, 5'd3, 32'h99, 1'b0, 5'd0, 32'h0);
        vecs[4]  = v_mem(L_TYPE, LS_B, 32'h103, 32'h0, 5'd7, 32'h80FF_FF00, 1'b0,
                         32'h100, 4'b1000, 32'h0, 1'b1, 5'd7, 32'hFFFF_FF80);
        vecs[5]  = v_mem(L_TYPE, LS_BU, 32'h103, 32'h0, 5'd7, 32'h80FF_FF00, 1'b0,
                         32'h100, 4'b1000, 32'h0, 1'b1, 5'd7, 32'h0000_0080);
        vecs[6]  = v_mem(S_TYPE, LS_H, 32'h202, 32'hABCD, 5'd9, 32'h1111_1111, 1'b0,
                         32'h200, 4'b1100, 32'hABCD_ABCD, 1'b0, 5'd0, 32'h0);
        vecs[7]  = v_mem(L_TYPE, LS_W, 32'h101, 32'h0, 5'd3, 32'h0, 1'b1,
                         32'h0, 4'h0, 32'h0, 1'b0, 5'd0, 32'h0);
        vecs[8]  = v_mem(L_TYPE, LS_H, 32'h102, 32'h0, 5'd4, 32'h8001_1234, 1'b0,
                         32'h100, 4'b1100, 32'h0, 1'b1, 5'd4, 32'hFFFF_8001);
        vecs[9]  = v_mem(L_TYPE, LS_HU, 32'h102, 32'h0, 5'd4, 32'h8001_1234, 1'b0,
                         32'h100, 4'b1100, 32'h0, 1'b1, 5'd4, 32'h0000_8001);
        vecs[10] = v_mem(S_TYPE, LS_B, 32'h301, 32'h1234_5678, 5'd0, 32'h0, 1'b0,
                         32'h300, 4'b0010, 32'h7878_7878, 1'b0, 5'd0, 32'h0);
        vecs[11] = v_mem(S_TYPE, LS_W, 32'h400, 32'hCAFE_BABE, 5'd0, 32'h0, 1'b0,
                         32'h400, 4'hF, 32'hCAFE_BABE, 1'b0, 5'd0, 32'h0);
        vecs[12] = v_mem(L_TYPE, LS_W, 32'h400, 32'h0, 5'd31, 32'h1357_9BDF, 1'b0,
                         32'h400, 4'hF, 32'h0, 1'b1, 5'd31, 32'h1357_9BDF);
        vecs[13] = v_mem(L_TYPE, LS_B, 32'h100, 32'h0, 5'd0, 32'h0000_007F, 1'b0,
                         32'h100, 4'b0001, 32'h0, 1'b0, 5'd0, 32'h0);

        // Reset state
        #12;
        chk("rst dmem_req", dmem_req, 0);
        chk("rst mem_stall", mem_stall, 0);
        chk("rst wb_valid", wb_valid, 0);
        chk("rst bp_mem_reg", bp_mem_reg, 0);
        chk("rst bp_mem_val", bp_mem_val, 0);
        chk("rst dmem_be", dmem_be, 0);
        chk("rst errs", {misalign_err, bus_err}, 0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 14; i++) begin
            drive(vecs[i].typ, vecs[i].sub, vecs[i].val, vecs[i].st, vecs[i].rd);
            if (vecs[i].is_mem && !vecs[i].e_mis) begin
                chk($sformatf("v%0d req", i), dmem_req, 1);
                chk($sformatf("v%0d stall", i), mem_stall, 1);
                chk($sformatf("v%0d addr", i), dmem_addr, vecs[i].e_addr);
                chk($sformatf("v%0d be", i), dmem_be, vecs[i].e_be);
                chk($sformatf("v%0d wdata", i), dmem_wdata, vecs[i].e_wdata);
                chk($sformatf("v%0d we", i), dmem_we, vecs[i].e_we);
                chk($sformatf("v%0d wbv pend", i), wb_valid, 0);
                chk($sformatf("v%0d bpr pend", i), bp_mem_reg, 0);
                dmem_ack = 1'b1;
                dmem_rdata = vecs[i].rdata;
                @(negedge clk);
                dmem_ack = 1'b0;
                dmem_rdata = 32'h0;
                chk($sformatf("v%0d req done", i), dmem_req, 0);
                chk($sformatf("v%0d stall done", i), mem_stall, 0);
                chk($sformatf("v%0d wb_valid", i), wb_valid, vecs[i].a_wbv);
                chk($sformatf("v%0d bp_reg", i), bp_mem_reg, vecs[i].a_rd);
                chk($sformatf("v%0d bp_val", i), bp_mem_val,
                    vecs[i].a_wbv ? vecs[i].a_val : 32'h0);
                if (vecs[i].a_wbv) begin
                    chk($sformatf("v%0d wb_reg", i), wb_reg, vecs[i].a_rd);
                    chk($sformatf("v%0d wb_val", i), wb_val, vecs[i].a_val);
                end
            end else if (vecs[i].is_mem) begin
                chk($sformatf("v%0d misalign", i), misalign_err, 1);
                chk($sformatf("v%0d mis req", i), dmem_req, 0);
                chk($sformatf("v%0d mis stall", i), mem_stall, 0);
                chk($sformatf("v%0d mis wbv", i), wb_valid, 0);
                chk($sformatf("v%0d mis bpr", i), bp_mem_reg, 0);
                @(negedge clk);
                chk($sformatf("v%0d misalign pulse", i), misalign_err, 0);
            end else begin
                chk($sformatf("v%0d wb_valid", i), wb_valid, vecs[i].e_wbv);
                chk($sformatf("v%0d bp_reg", i), bp_mem_reg, vecs[i].e_bpr);
                chk($sformatf("v%0d bp_val", i), bp_mem_val, vecs[i].e_bpv);
                chk($sformatf("v%0d stall", i), mem_stall, 0);
                chk($sformatf("v%0d req", i), dmem_req, 0);
                if (vecs[i].e_wbv) begin
                    chk($sformatf("v%0d wb_reg", i), wb_reg, vecs[i].rd);
                    chk($sformatf("v%0d wb_val", i), wb_val, vecs[i].val);
                end
            end
        end

        // Idle cycle clears the writeback strobe; spurious ack is ignored
        @(negedge clk);
        dmem_ack = 1'b1;
        dmem_rdata = 32'hFFFF_FFFF;
        @(negedge clk);
        dmem_ack = 1'b0;
        dmem_rdata = 32'h0;
        chk("spur wb_valid", wb_valid, 0);
        chk("spur req", dmem_req, 0);
        chk("spur stall", mem_stall, 0);

        // LB with ack in the third ACCESS cycle
        drive(L_TYPE, LS_B, 32'h103, 32'h0, 5'd10);
        for (int k = 0; k < 2; k++) begin
            chk($sformatf("lb wait%0d stall", k), mem_stall, 1);
            chk($sformatf("lb wait%0d req", k), dmem_req, 1);
            chk($sformatf("lb wait%0d wbv", k), wb_valid, 0);
            @(negedge clk);
        end
        dmem_ack = 1'b1;
        dmem_rdata = 32'h80FF_FF00;
        @(negedge clk);
        dmem_ack = 1'b0;
        chk("lb slow wb_val", wb_val, 32'hFFFF_FF80);
        chk("lb slow wb_reg", wb_reg, 10);
        chk("lb slow bp_val", bp_mem_val, 32'hFFFF_FF80);
        chk("lb slow bus_err", bus_err, 0);

        // Timeout: request held ACK_TIMEOUT cycles then abort
        drive(L_TYPE, LS_W, 32'h500, 32'h0, 5'd6);
        n = 0;
        while (dmem_req && n < 10) begin
            n++;
            @(negedge clk);
        end
        chk("to req cycles", n, 4);
        chk("to bus_err", bus_err, 1);
        chk("to stall", mem_stall, 0);
        chk("to wb_valid", wb_valid, 0);
        chk("to bp_reg", bp_mem_reg, 0);
        @(negedge clk);
        chk("to bus_err pulse", bus_err, 0);

        // Ack arriving in the timeout cycle wins
        drive(L_TYPE, LS_W, 32'h700, 32'h0, 5'd8);
        repeat (3) @(negedge clk);
        chk("race req", dmem_req, 1);
        dmem_ack = 1'b1;
        dmem_rdata = 32'h0000_A5A5;
        @(negedge clk);
        dmem_ack = 1'b0;
        chk("race bus_err", bus_err, 0);
        chk("race wb_valid", wb_valid, 1);
        chk("race wb_val", wb_val, 32'h0000_A5A5);

        // Reset mid-access drops the request asynchronously
        drive(L_TYPE, LS_W, 32'h600, 32'h0, 5'd2);
        chk("mid req before rst", dmem_req, 1);
        #2 rst_n = 1'b0;
        #1;
        chk("mid rst req", dmem_req, 0);
        chk("mid rst stall", mem_stall, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("post rst req", dmem_req, 0);

        // Load to x0 after reset
        drive(L_TYPE, LS_W, 32'h10, 32'h0, 5'd0);
        chk("x0 req", dmem_req, 1);
        dmem_ack = 1'b1;
        dmem_rdata = 32'h0000_0055;
        @(negedge clk);
        dmem_ack = 1'b0;
        chk("x0 wb_valid", wb_valid, 0);
        chk("x0 bp_val", bp_mem_val, 0);
        chk("x0 bp_reg", bp_mem_reg, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Safety net against a hung run
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

endmodule
